// File: rtl/shift_reg4_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg4_pkg
//   Shared constants and helpers for the shift_reg4 delay line.
//   - SR_DEPTH_DEFAULT      : default number of storage stages
//   - SR_RESET_BIT_DEFAULT  : default per-stage reset value (replicated DEPTH times)
//   - sr_op_e / sr_decode_op: per-edge operation selected from load / shiftEn
// -----------------------------------------------------------------------------
package shift_reg4_pkg;

    localparam int   SR_DEPTH_DEFAULT     = 4;
    localparam logic SR_RESET_BIT_DEFAULT = 1'b0;

    typedef enum logic [1:0] {
        SR_OP_HOLD  = 2'd0,
        SR_OP_SHIFT = 2'd1,
        SR_OP_LOAD  = 2'd2
    } sr_op_e;

    // Parallel load has priority over shifting; with neither requested the
    // register holds.
    function automatic sr_op_e sr_decode_op(input logic load, input logic shift_en);
        if (load) begin
            return SR_OP_LOAD;
        end
        if (shift_en) begin
            return SR_OP_SHIFT;
        end
        return SR_OP_HOLD;
    endfunction

endpackage : shift_reg4_pkg

// File: rtl/shift_reg4_shift_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
//   One storage stage of the shift register: a single flop with enable and an
//   asynchronous active-low reset to a per-stage constant.
//   Ports:
//     i_clk   - rising-edge clock
//     i_rst_n - asynchronous active-low reset
//     i_en    - capture enable (load or shift this edge)
//     i_d     - next value when enabled
//     o_q     - stored value
// -----------------------------------------------------------------------------
module shift_stage
    import shift_reg4_pkg::*;
#(
    parameter logic RESET_BIT = SR_RESET_BIT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_d,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RESET_BIT;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : shift_stage

// File: rtl/shift_reg4.sv
// -----------------------------------------------------------------------------
// shift_reg4
//   Serial-in / serial-out shift register (delay line) with shift enable,
//   synchronous parallel load and a parallel tap of every stage.
//   Stage 0 is the input end, stage DEPTH-1 drives the serial output.
//   Ports:
//     clock       - rising-edge clock
//     reset_n     - asynchronous active-low reset, clears stages to RESET_VALUE
//     shiftIn     - serial data into stage 0
//     shiftEn     - shift enable (tie high for free-running shift)
//     load        - synchronous parallel load request, wins over shiftEn
//     loadData    - parallel load value, bit i -> stage i
//     shiftOut    - stage DEPTH-1, combinational from the flop
//     parallelOut - all stages, bit i = stage i
// -----------------------------------------------------------------------------
module shift_reg4
    import shift_reg4_pkg::*;
#(
    parameter int               DEPTH       = SR_DEPTH_DEFAULT,
    parameter logic [DEPTH-1:0] RESET_VALUE = {DEPTH{SR_RESET_BIT_DEFAULT}}
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             shiftIn,
    input  logic             shiftEn,
    input  logic             load,
    input  logic [DEPTH-1:0] loadData,
    output logic             shiftOut,
    output logic [DEPTH-1:0] parallelOut
);

    sr_op_e           w_op;
    logic             w_stage_en;
    logic [DEPTH-1:0] w_stage_d;
    logic [DEPTH-1:0] w_stage_q;

    // Named taps of the four stages for the default depth; they are the
    // hierarchical handles bit0 (input end) .. bit3 (output end).
    logic bit0;
    logic bit1;
    logic bit2;
    logic bit3;

    assign w_op       = sr_decode_op(load, shiftEn);
    assign w_stage_en = (w_op != SR_OP_HOLD);

    always_comb begin
        w_stage_d = w_stage_q;
        case (w_op)
            SR_OP_LOAD:  w_stage_d = loadData;
            SR_OP_SHIFT: w_stage_d = {w_stage_q[DEPTH-2:0], shiftIn};
            default:     w_stage_d = w_stage_q;
        endcase
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            shift_stage #(
                .RESET_BIT (RESET_VALUE[gi])
            ) u_stage (
                .i_clk   (clock),
                .i_rst_n (reset_n),
                .i_en    (w_stage_en),
                .i_d     (w_stage_d[gi]),
                .o_q     (w_stage_q[gi])
            );
        end

        if (DEPTH == 4) begin : g_named
            assign bit0        = w_stage_q[0];
            assign bit1        = w_stage_q[1];
            assign bit2        = w_stage_q[2];
            assign bit3        = w_stage_q[3];
            assign parallelOut = {bit3, bit2, bit1, bit0};
        end else begin : g_generic
            // Named taps only have meaning for the four-stage build.
            assign bit0        = 1'b0;
            assign bit1        = 1'b0;
            assign bit2        = 1'b0;
            assign bit3        = 1'b0;
            assign parallelOut = w_stage_q;
        end
    endgenerate

    assign shiftOut = parallelOut[DEPTH-1];

endmodule : shift_reg4

// File: tb/tb_shift_reg4.sv
module tb_shift_reg4;

    logic       clock;
    logic       reset_n;
    logic       shiftIn;
    logic       shiftEn;
    logic       load;
    logic [3:0] loadData;
    logic       shiftOut;
    logic [3:0] parallelOut;

    int n_checks = 0;
    int n_errors = 0;

    shift_reg4 dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .shiftIn     (shiftIn),
        .shiftEn     (shiftEn),
        .load        (load),
        .loadData    (loadData),
        .shiftOut    (shiftOut),
        .parallelOut (parallelOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       ld;
        logic       en;
        logic       si;
        logic [3:0] ldata;
        logic [3:0] exp_par;
    } vec_t;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic ld, input logic en, input logic si, input logic [3:0] ldata);
        load     = ld;
        shiftEn  = en;
        shiftIn  = si;
        loadData = ldata;
    endtask

    // Async reset pulse placed between clock edges.
    task automatic reset_pulse();
        #2;
        reset_n = 1'b0;
        #1;
        check4("reset_async_par", parallelOut, 4'b0000);
        check1("reset_async_out", shiftOut, 1'b0);
        #1;
        reset_n = 1'b1;
    endtask

    vec_t vecs[12];
    logic [3:0] model;
    logic wave[$];

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 4'b0000);

        // Reset held with random serial input across edges.
        for (int i = 0; i < 4; i++) begin
            shiftIn = 1'($urandom);
            step();
            check4("reset_hold_par", parallelOut, 4'b0000);
            check1("reset_hold_out", shiftOut, 1'b0);
        end
        reset_n = 1'b1;

        // Reset asserted between edges clears a full register without a clock.
        drive(1'b1, 1'b0, 1'b0, 4'b1111);
        step();
        check4("load_1111", parallelOut, 4'b1111);
        drive(1'b0, 1'b0, 1'b0, 4'b0000);
        reset_pulse();

        // Single pulse.
        drive(1'b0, 1'b1, 1'b1, 4'b0000);
        step();
        check4("pulse_e1", parallelOut, 4'b0001);
        check1("pulse_out_e1", shiftOut, 1'b0);
        shiftIn = 1'b0;
        step(); check4("pulse_e2", parallelOut, 4'b0010); check1("pulse_out_e2", shiftOut, 1'b0);
        step(); check4("pulse_e3", parallelOut, 4'b0100); check1("pulse_out_e3", shiftOut, 1'b0);
        step(); check4("pulse_e4", parallelOut, 4'b1000); check1("pulse_out_e4", shiftOut, 1'b1);
        step(); check4("pulse_e5", parallelOut, 4'b0000); check1("pulse_out_e5", shiftOut, 1'b0);

        // Long pulses: 5 high, 6 low, 7 high, 4 low; output is the input delayed.
        wave.delete();
        for (int i = 0; i < 5; i++) wave.push_back(1'b1);
        for (int i = 0; i < 6; i++) wave.push_back(1'b0);
        for (int i = 0; i < 7; i++) wave.push_back(1'b1);
        for (int i = 0; i < 4; i++) wave.push_back(1'b0);
        for (int k = 0; k < wave.size() + 4; k++) begin
            shiftIn = (k < wave.size()) ? wave[k] : 1'b0;
            step();
            check1("long_pulse_out", shiftOut, (k >= 3 && k - 3 < wave.size()) ? wave[k-3] : 1'b0);
        end

        // Enable hold.
        drive(1'b1, 1'b1, 1'b0, 4'b1010);
        step();
        check4("hold_load", parallelOut, 4'b1010);
        drive(1'b0, 1'b0, 1'b1, 4'b0101);
        for (int i = 0; i < 3; i++) begin
            step();
            check4("hold_par", parallelOut, 4'b1010);
            check1("hold_out", shiftOut, 1'b1);
        end
        drive(1'b0, 1'b1, 1'b0, 4'b0000);
        step(); check1("hold_resume_1", shiftOut, 1'b0);
        step(); check1("hold_resume_2", shiftOut, 1'b1);
        step(); check1("hold_resume_3", shiftOut, 1'b0);
        step(); check1("hold_resume_4", shiftOut, 1'b0);

        // Load wins over shift on the same edge.
        drive(1'b1, 1'b1, 1'b1, 4'b0110);
        step();
        check4("load_prio_par", parallelOut, 4'b0110);
        check1("load_prio_out", shiftOut, 1'b0);

        // Reset mid-operation.
        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        step();
        drive(1'b0, 1'b1, 1'b1, 4'b0000);
        step(); step(); step();
        check4("mid_shifted", parallelOut, 4'b0111);
        reset_pulse();
        shiftIn = 1'b0;
        step();
        check4("mid_restart_0", parallelOut, 4'b0000);
        shiftIn = 1'b1;
        step();
        check4("mid_restart_1", parallelOut, 4'b0001);

        // Table-driven vectors from a cleared register.
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b0001};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'b1111, 4'b0010};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 4'b1111, 4'b0010};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b0101};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'b1100, 4'b1100};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b1001};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 4'b0011, 4'b0011};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b0111};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b1111};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1110};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b1110};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1100};
        drive(1'b0, 1'b0, 1'b0, 4'b0000);
        reset_pulse();
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].ld, vecs[i].en, vecs[i].si, vecs[i].ldata);
            step();
            check4("vec_par", parallelOut, vecs[i].exp_par);
            check1("vec_out", shiftOut, vecs[i].exp_par[3]);
        end

        // Random stimulus against an arithmetic model of the register value.
        drive(1'b0, 1'b0, 1'b0, 4'b0000);
        reset_pulse();
        model = 4'd0;
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), 4'($urandom));
            if (load)
                model = loadData;
            else if (shiftEn)
                model = 4'((model * 2 + shiftIn) % 16);
            step();
            check4("rand_par", parallelOut, model);
            check1("rand_out", shiftOut, model >= 4'd8);
            if ($urandom_range(0, 49) == 0) begin
                reset_pulse();
                model = 4'd0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_shift_reg4
